alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Integer execution stage downstream of the reservation station. Accepts at most one ready
//  RV32I arithmetic, logic, shift, branch or jump op per cycle (operands already resolved).
//  Computes the result and branch outcome, then broadcasts it on the execution CDB to the RS,
//  LSB and ROB. Fixed latency of one cycle; result outputs are registered.
// PARAMETERS
//  XLEN      32  datapath width
//  ROBIDW    32  width of ROB tag carried with each op
// PORTS
//  clk               in   1       clock
//  rst               in   1       reset, synchronous, active-high
//  rdy               in   1       global enable; low = freeze all state
//  jump_wrong_stall  in   1       mispredict flush
//  in_flag           in   1       op valid this cycle (RS ALU_flag)
//  in_V1             in   XLEN    rs1 value
//  in_V2             in   XLEN    rs2 value (R-type / branch only)
//  in_A              in   XLEN    sign-extended immediate, or U-imm already shifted
//  in_pc             in   XLEN    instruction pc
//  in_code           in   6       `Def.v inst code (`ADD..`AND, `ADDI..`SRAI, `LUI, `AUIPC, `JAL, `JALR, `BEQ..`BGEU)
//  in_rob_id         in   ROBIDW  ROB tag
//  ex_cdb_flag       out  1       result valid
//  ex_cdb_rob_id     out  ROBIDW  tag of result
//  ex_cdb_val        out  XLEN    rd value (0 for branches)
//  ex_cdb_jump       out  1       control transfer taken (branch taken, JAL, JALR)
//  ex_cdb_target     out  XLEN    resolved next pc (pc+4 when not taken)
// BEHAVIOUR
//  - Reset: ex_cdb_flag=0, ex_cdb_rob_id=0, ex_cdb_val=0, ex_cdb_jump=0, ex_cdb_target=0.
//  - Priority per posedge: rst > jump_wrong_stall > !rdy > normal.
//  - Flush: ex_cdb_flag<=0 next cycle; an in_flag in the flush cycle is dropped; other outputs don't care.
//  - !rdy: every output register holds its value, including ex_cdb_flag.
//  - Normal, in_flag=1: at edge N capture result; at N+1 ex_cdb_flag=1 with all fields valid.
//    Exactly one cycle high unless a new op arrives at N+1 (back-to-back, full throughput).
//  - Normal, in_flag=0: ex_cdb_flag<=0; data outputs may hold.
//  - Operand B: R-type and branch use in_V2; I-type, LUI and AUIPC use in_A.
//  - Arithmetic is modulo 2^XLEN (no overflow trap). SUB is V1-B.
//  - Shifts use B[4:0] only. SRA/SRAI are arithmetic; SRL/SRLI are logical.
//  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned (immediate is sign-extended first); result is 0/1.
//  - LUI: val=A. AUIPC: val=pc+A.
//  - JAL: val=pc+4, jump=1, target=pc+A.
//  - JALR: val=pc+4, jump=1, target=(V1+A)&~1.
//  - Branch: val=0; cond = BEQ ==, BNE !=, BLT/BGE signed, BLTU/BGEU unsigned.
//    jump=cond; target=cond ? pc+A : pc+4.
//  - Non-control ops: jump=0, target=pc+4.
//  - Unknown code: val=0, jump=0, target=pc+4, flag still asserted (ROB must retire it).
//  - No backpressure: consumers must accept every ex_cdb_flag pulse.
// TESTING
//  1 ADD V1=7,V2=5,rob=3 at N -> N+1 flag=1,rob=3,val=12,jump=0; N+2 flag=0.
//  2 SRAI V1=0x80000000,A=4 -> val=0xF8000000; SRLI same -> 0x08000000; SLL V2=0x21 shifts by 1.
//  3 SLT V1=-1,V2=1 -> 1; SLTU same -> 0; SLTIU V1=0,A=-1 -> 1.
//  4 BLT pc=0x100,V1=-2,V2=3,A=0x20 -> jump=1,target=0x120; BGEU V1=2,V2=3 -> jump=0,target=0x104.
//  5 JALR pc=0x40,V1=0x1001,A=2 -> val=0x44,target=0x1002,jump=1.
//  6 Back-to-back ADD/SUB, rdy low 2 cycles mid-stream, then flush with in_flag=1 ->
//    outputs frozen while rdy low; no flag after flush; rst mid-op -> all outputs 0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Single-cycle RV32I integer execution unit feeding the execution CDB.
// Instruction codes live in alu_pkg and are shared with the decode side.
package alu_pkg;
  localparam logic [5:0] C_LUI   = 6'd1;
  localparam logic [5:0] C_AUIPC = 6'd2;
  localparam logic [5:0] C_JAL   = 6'd3;
  localparam logic [5:0] C_JALR  = 6'd4;
  localparam logic [5:0] C_BEQ   = 6'd5;
  localparam logic [5:0] C_BNE   = 6'd6;
  localparam logic [5:0] C_BLT   = 6'd7;
  localparam logic [5:0] C_BGE   = 6'd8;
  localparam logic [5:0] C_BLTU  = 6'd9;
  localparam logic [5:0] C_BGEU  = 6'd10;
  localparam logic [5:0] C_ADDI  = 6'd19;
  localparam logic [5:0] C_SLTI  = 6'd20;
  localparam logic [5:0] C_SLTIU = 6'd21;
  localparam logic [5:0] C_XORI  = 6'd22;
  localparam logic [5:0] C_ORI   = 6'd23;
  localparam logic [5:0] C_ANDI  = 6'd24;
  localparam logic [5:0] C_SLLI  = 6'd25;
  localparam logic [5:0] C_SRLI  = 6'd26;
  localparam logic [5:0] C_SRAI  = 6'd27;
  localparam logic [5:0] C_ADD   = 6'd28;
  localparam logic [5:0] C_SUB   = 6'd29;
  localparam logic [5:0] C_SLL   = 6'd30;
  localparam logic [5:0] C_SLT   = 6'd31;
  localparam logic [5:0] C_SLTU  = 6'd32;
  localparam logic [5:0] C_XOR   = 6'd33;
  localparam logic [5:0] C_SRL   = 6'd34;
  localparam logic [5:0] C_SRA   = 6'd35;
  localparam logic [5:0] C_OR    = 6'd36;
  localparam logic [5:0] C_AND   = 6'd37;
endpackage

module alu_exec_unit #(
  parameter int XLEN   = 32,
  parameter int ROBIDW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jump_wrong_stall,
  input  logic              in_flag,
  input  logic [XLEN-1:0]   in_V1,
  input  logic [XLEN-1:0]   in_V2,
  input  logic [XLEN-1:0]   in_A,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [5:0]        in_code,
  input  logic [ROBIDW-1:0] in_rob_id,
  output logic              ex_cdb_flag,
  output logic [ROBIDW-1:0] ex_cdb_rob_id,
  output logic [XLEN-1:0]   ex_cdb_val,
  output logic              ex_cdb_jump,
  output logic [XLEN-1:0]   ex_cdb_target
);
  import alu_pkg::*;

  localparam logic [XLEN-1:0] ONE  = XLEN'(1);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic            use_v2;
  logic [XLEN-1:0] opb;
  logic [4:0]      sh;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] pc_a;
  logic            lt_s;
  logic            lt_u;
  logic            eq;
  logic            cond;
  logic            is_br;
  logic [XLEN-1:0] res_val;
  logic            res_jump;
  logic [XLEN-1:0] res_tgt;

  // R-type and branches compare/operate on rs2; everything else on the immediate
  assign use_v2 = (in_code >= C_ADD && in_code <= C_AND)
               || (in_code >= C_BEQ && in_code <= C_BGEU);
  assign opb  = use_v2 ? in_V2 : in_A;
  assign sh   = opb[4:0];
  assign pc4  = in_pc + FOUR;
  assign pc_a = in_pc + in_A;
  assign lt_s = $signed(in_V1) < $signed(opb);
  assign lt_u = in_V1 < opb;
  assign eq   = in_V1 == opb;

  always_comb begin
    cond  = 1'b0;
    is_br = 1'b1;
    case (in_code)
      C_BEQ:   cond = eq;
      C_BNE:   cond = !eq;
      C_BLT:   cond = lt_s;
      C_BGE:   cond = !lt_s;
      C_BLTU:  cond = lt_u;
      C_BGEU:  cond = !lt_u;
      default: is_br = 1'b0;
    endcase
  end

  always_comb begin
    res_val  = '0;
    res_jump = 1'b0;
    res_tgt  = pc4;
    case (in_code)
      C_ADD, C_ADDI:   res_val = in_V1 + opb;
      C_SUB:           res_val = in_V1 - opb;
      C_SLL, C_SLLI:   res_val = in_V1 << sh;
      C_SLT, C_SLTI:   res_val = lt_s ? ONE : '0;
      C_SLTU, C_SLTIU: res_val = lt_u ? ONE : '0;
      C_XOR, C_XORI:   res_val = in_V1 ^ opb;
      C_SRL, C_SRLI:   res_val = in_V1 >> sh;
      C_SRA, C_SRAI:   res_val = $signed(in_V1) >>> sh;
      C_OR, C_ORI:     res_val = in_V1 | opb;
      C_AND, C_ANDI:   res_val = in_V1 & opb;
      C_LUI:           res_val = in_A;
      C_AUIPC:         res_val = pc_a;
      C_JAL: begin
        res_val  = pc4;
        res_jump = 1'b1;
        res_tgt  = pc_a;
      end
      C_JALR: begin
        res_val  = pc4;
        res_jump = 1'b1;
        res_tgt  = (in_V1 + in_A) & ~ONE;
      end
      default: begin
        if (is_br) begin
          res_jump = cond;
          res_tgt  = cond ? pc_a : pc4;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_cdb_flag   <= 1'b0;
      ex_cdb_rob_id <= '0;
      ex_cdb_val    <= '0;
      ex_cdb_jump   <= 1'b0;
      ex_cdb_target <= '0;
    end else if (jump_wrong_stall) begin
      ex_cdb_flag <= 1'b0;
    end else if (rdy) begin
      ex_cdb_flag <= in_flag;
      if (in_flag) begin
        ex_cdb_rob_id <= in_rob_id;
        ex_cdb_val    <= res_val;
        ex_cdb_jump   <= res_jump;
        ex_cdb_target <= res_tgt;
      end
    end
  end
endmodule
